// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port; data wins ties.
// Optional mem_ready watchdog is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        arb_eqmem,
  output logic        memOp_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_t;

  // state_q is the single point of truth for the FSM and is meant to be probed.
  state_t      state_q, state_d;
  logic        grant_d, grant_if;
  logic        timeout_hit;
  logic [3:0]  d_be;
  logic [31:0] d_wdata_rep;

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic        if_valid_q, d_done_q;
  logic [31:0] if_rdata_q, d_rdata_q;

  always_comb begin
    d_be        = 4'b1111;
    d_wdata_rep = d_wdata;
    case (d_size)
      2'd0: begin
        d_be        = 4'b0001 << d_addr[1:0];
        d_wdata_rep = {4{d_wdata[7:0]}};
      end
      2'd1: begin
        d_be        = 4'b0011 << {d_addr[1], 1'b0};
        d_wdata_rep = {2{d_wdata[15:0]}};
      end
      default: begin
        d_be        = 4'b1111;
        d_wdata_rep = d_wdata;
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT_CYCLES);
  logic [15:0] tmo_cnt;
  logic        if_err_q, d_err_q;

  // The limit is reached on the BUSY cycle whose increment would hit TIMEOUT_CYCLES;
  // mem_ready in that same cycle takes precedence.
  assign timeout_hit = (state_q != IDLE) && !mem_ready &&
                       (({1'b0, tmo_cnt} + 17'd1) == TMO_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt  <= 16'd0;
      if_err_q <= 1'b0;
      d_err_q  <= 1'b0;
    end else begin
      if_err_q <= 1'b0;
      d_err_q  <= 1'b0;
      if (grant_d || grant_if) begin
        tmo_cnt <= 16'd0;
      end else if (state_q != IDLE && !mem_ready) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
      if (timeout_hit) begin
        if_err_q <= (state_q == IF_BUSY);
        d_err_q  <= (state_q == D_BUSY);
      end
    end
  end

  assign if_err = if_err_q;
  assign d_err  = d_err_q;
`else
  assign timeout_hit = 1'b0;
  assign if_err      = 1'b0;
  assign d_err       = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = 1'b0;
    grant_if = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d = D_BUSY;
          grant_d = 1'b1;
        end else if (if_req) begin
          state_d  = IF_BUSY;
          grant_if = 1'b1;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (mem_ready || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lat_we     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_be     <= 4'd0;
      if_valid_q <= 1'b0;
      d_done_q   <= 1'b0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= 1'b0;
      d_done_q   <= 1'b0;
      if (grant_d) begin
        lat_we    <= d_we;
        lat_addr  <= d_addr;
        lat_wdata <= d_wdata_rep;
        lat_be    <= d_be;
      end else if (grant_if) begin
        lat_we    <= 1'b0;
        lat_addr  <= if_addr;
        lat_wdata <= 32'd0;
        lat_be    <= 4'b1111;
      end
      // Timeout completions pulse done but leave the rdata registers alone.
      if (state_q == IF_BUSY && (mem_ready || timeout_hit)) begin
        if_valid_q <= 1'b1;
        if (mem_ready) if_rdata_q <= mem_rdata;
      end
      if (state_q == D_BUSY && (mem_ready || timeout_hit)) begin
        d_done_q <= 1'b1;
        if (mem_ready) d_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_req    = (state_q != IDLE);
  assign mem_we     = lat_we;
  assign mem_addr   = lat_addr;
  assign mem_wdata  = lat_wdata;
  assign mem_be     = lat_be;
  assign arb_eqmem  = (state_q == D_BUSY) || (state_q == IDLE && d_req);
  assign if_valid   = if_valid_q;
  assign if_rdata   = if_rdata_q;
  assign memOp_done = d_done_q;
  assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever a done pulse appears.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        arb_eqmem;
  logic        memOp_done;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  // Expected completion: {is_data, err, rdata}
  logic [33:0] exp_q[$];
  logic        prev_pulse = 1'b0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .arb_eqmem(arb_eqmem), .memOp_done(memOp_done),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [33:0] e;
    if (if_valid || memOp_done) begin
      check("pulse_width", {31'd0, prev_pulse}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got if_valid=%b memOp_done=%b want no pulse",
                 if_valid, memOp_done);
      end else begin
        e = exp_q.pop_front();
        check("done_kind", {30'd0, memOp_done, if_valid}, e[33] ? 32'd2 : 32'd1);
        if (e[33]) begin
          check("d_err", {31'd0, d_err}, {31'd0, e[32]});
          check("d_rdata", d_rdata, e[31:0]);
        end else begin
          check("if_err", {31'd0, if_err}, {31'd0, e[32]});
          check("if_rdata", if_rdata, e[31:0]);
        end
      end
    end
    prev_pulse = if_valid || memOp_done;
  end

  // Driver: one access, held for 'waits' BUSY cycles before mem_ready.
  task automatic run_access(input bit is_data, input logic we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int waits, input logic [31:0] rdata,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input string tag);
    if (is_data) begin
      d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    tick;
    d_req = 1'b0; if_req = 1'b0;
    d_addr = 32'hFFFF_FFFF; d_wdata = 32'h0; d_we = 1'b0; d_size = 2'd0; if_addr = 32'h0;
    check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
    check({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
    check({tag, "_mem_addr"}, mem_addr, addr);
    check({tag, "_mem_be"}, {28'd0, mem_be}, {28'd0, exp_be});
    if (we) check({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
    check({tag, "_arb_eqmem"}, {31'd0, arb_eqmem}, {31'd0, is_data});
    repeat (waits) tick;
    mem_ready = 1'b1; mem_rdata = rdata;
    exp_q.push_back({is_data, 1'b0, rdata});
    tick;
    mem_ready = 1'b0; mem_rdata = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; d_size = 2'd0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_done", {30'd0, if_valid, memOp_done}, 32'd0);
    check("rst_err", {30'd0, if_err, d_err}, 32'd0);
    check("rst_rdata", if_rdata | d_rdata, 32'd0);
    check("rst_arb_eqmem", {31'd0, arb_eqmem}, 32'd0);
    rst = 1'b0;
    tick;

    // mem_ready in IDLE must be ignored
    mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick; tick;
    check("idle_ready_mem_req", {31'd0, mem_req}, 32'd0);
    check("idle_ready_rdata", d_rdata | if_rdata, 32'd0);
    mem_ready = 1'b0; mem_rdata = 32'h0;

    // Directed accesses
    run_access(1'b0, 1'b0, 2'd0, 32'h0000_0100, 32'h0, 1, 32'hCAFE_0001, 4'b1111, 32'h0, "fetch");
    run_access(1'b1, 1'b1, 2'd0, 32'h0000_0203, 32'h0000_00AB, 0, 32'h0000_0010, 4'b1000, 32'hABAB_ABAB, "sb203");
    run_access(1'b1, 1'b1, 2'd1, 32'h0000_0002, 32'h0000_1234, 2, 32'h0000_0020, 4'b1100, 32'h1234_1234, "sh002");
    run_access(1'b1, 1'b1, 2'd0, 32'h0000_0201, 32'hFFFF_FF5C, 0, 32'h0000_0030, 4'b0010, 32'h5C5C_5C5C, "sb201");
    run_access(1'b1, 1'b1, 2'd1, 32'h0000_0300, 32'hAAAA_BEEF, 1, 32'h0000_0040, 4'b0011, 32'hBEEF_BEEF, "sh300");
    run_access(1'b1, 1'b0, 2'd2, 32'h0000_0040, 32'h0, 0, 32'h8765_4321, 4'b1111, 32'h0, "lw040");
    run_access(1'b1, 1'b1, 2'd3, 32'h0000_0044, 32'hDEAD_BEEF, 0, 32'h0000_0050, 4'b1111, 32'hDEAD_BEEF, "sz3");

    // Simultaneous requests: data first, fetch granted in the done cycle
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h0000_0400;
    if_req = 1'b1; if_addr = 32'h0000_0500;
    #1;
    check("both_idle_arb_eqmem", {31'd0, arb_eqmem}, 32'd1);
    tick;
    d_req = 1'b0;
    check("both_first_addr", mem_addr, 32'h0000_0400);
    check("both_dbusy_arb_eqmem", {31'd0, arb_eqmem}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    exp_q.push_back({1'b1, 1'b0, 32'h1111_2222});
    exp_q.push_back({1'b0, 1'b0, 32'h3333_4444});
    tick;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    check("both_done_pulse", {31'd0, memOp_done}, 32'd1);
    check("both_done_mem_req", {31'd0, mem_req}, 32'd0);
    check("both_done_arb_eqmem", {31'd0, arb_eqmem}, 32'd0);
    tick;
    if_req = 1'b0;
    check("both_fetch_mem_req", {31'd0, mem_req}, 32'd1);
    check("both_fetch_addr", mem_addr, 32'h0000_0500);
    check("both_fetch_we", {31'd0, mem_we}, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h3333_4444;
    tick;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    tick;
    check("hold_d_rdata", d_rdata, 32'h1111_2222);
    check("hold_if_rdata", if_rdata, 32'h3333_4444);

    // Reset in D_BUSY aborts with no done pulse
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 32'h0000_0600; d_wdata = 32'h5555_6666;
    tick;
    d_req = 1'b0;
    check("rstmid_busy", {31'd0, mem_req}, 32'd1);
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h9999_9999;
    tick;
    check("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
    check("rstmid_mem_fields", mem_addr | mem_wdata | {28'd0, mem_be} | {31'd0, mem_we}, 32'd0);
    check("rstmid_rdata", d_rdata | if_rdata, 32'd0);
    check("rstmid_arb_eqmem", {31'd0, arb_eqmem}, 32'd0);
    mem_ready = 1'b0; mem_rdata = 32'h0; rst = 1'b0;
    tick; tick;
    check("rstmid_no_done", {30'd0, if_valid, memOp_done}, 32'd0);

`ifdef ARB_TIMEOUT_EN
    // Data timeout: no mem_ready, done+err after the 4th BUSY cycle
    exp_q.push_back({1'b1, 1'b1, 32'h0});
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h0000_0700;
    tick;
    d_req = 1'b0;
    repeat (3) tick;
    check("tmo_busy4_mem_req", {31'd0, mem_req}, 32'd1);
    tick;
    check("tmo_done_mem_req", {31'd0, mem_req}, 32'd0);
    check("tmo_d_err", {31'd0, d_err}, 32'd1);
    tick; tick;

    // mem_ready on the limit cycle wins
    d_req = 1'b1; d_addr = 32'h0000_0704;
    tick;
    d_req = 1'b0;
    repeat (3) tick;
    mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    exp_q.push_back({1'b1, 1'b0, 32'h7777_7777});
    tick;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    check("tmo_race_d_err", {31'd0, d_err}, 32'd0);
    tick;

    // Fetch timeout keeps the old fetch data
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    if_req = 1'b1; if_addr = 32'h0000_0800;
    tick;
    if_req = 1'b0;
    repeat (4) tick;
    check("tmo_if_err", {31'd0, if_err}, 32'd1);
    tick;
`endif

    repeat (3) tick;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
